// File: rtl/cell_plot_queue_if.sv
// ============================================================================
// cell_plot_queue_if : event-in / pixel-out bundle for cell_plot_queue
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface cell_plot_queue_if #(
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_x;
    logic [6:0]        in_y;
    logic              in_alive;
    logic              clear_req;
    logic              clear_busy;
    logic [7:0]        x;
    logic [6:0]        y;
    logic [2:0]        colour;
    logic              plot;
    logic [ADDR_W:0]   fifo_count;
    logic              err_range;

    modport master (
        output in_valid, in_x, in_y, in_alive, clear_req,
        input  in_ready, clear_busy, x, y, colour, plot, fifo_count, err_range
    );

    modport slave (
        input  in_valid, in_x, in_y, in_alive, clear_req,
        output in_ready, clear_busy, x, y, colour, plot, fifo_count, err_range
    );
endinterface

`default_nettype wire

// File: rtl/cell_plot_queue.sv
// ============================================================================
// cell_plot_queue : FIFO of changed-cell events drained to the VGA adapter at
// one pixel per clock, plus a full-screen clear sweep.
// Optional macro: CELL_PLOT_RANGE_CHECK_EN (discard out-of-range events).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cell_plot_queue #(
    parameter int          DEPTH        = 16,
    parameter int          ADDR_W       = 4,
    parameter int          X_MAX        = 160,
    parameter int          Y_MAX        = 120,
    parameter logic [2:0]  ALIVE_COLOUR = 3'b111,
    parameter logic [2:0]  DEAD_COLOUR  = 3'b000
) (
    input  wire logic        clock,
    input  wire logic        reset,
    cell_plot_queue_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] C_FULL   = (ADDR_W+1)'(DEPTH);
    localparam logic [7:0]      C_X_LAST = 8'(X_MAX - 1);
    localparam logic [6:0]      C_Y_LAST = 7'(Y_MAX - 1);

    state_t             r_state, w_state_next;
    logic [15:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]    r_count;
    logic [7:0]         r_x, w_x_next;
    logic [6:0]         r_y, w_y_next;
    logic [2:0]         r_colour, w_colour_next;
    logic               r_plot, w_plot_next;
    logic               r_busy, w_busy_next;
    logic               w_push, w_store, w_pop, w_empty, w_sweep_last;
    logic [15:0]        w_head;

    assign w_empty      = (r_count == '0);
    assign bus.in_ready = (r_count != C_FULL);
    assign w_push       = bus.in_valid & bus.in_ready;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_sweep_last = (r_x == C_X_LAST) && (r_y == C_Y_LAST);

`ifdef CELL_PLOT_RANGE_CHECK_EN
    localparam logic [7:0] C_X_MAX = 8'(X_MAX);
    localparam logic [6:0] C_Y_MAX = 7'(Y_MAX);
    logic w_in_range;
    logic r_err_range;

    assign w_in_range    = (bus.in_x < C_X_MAX) && (bus.in_y < C_Y_MAX);
    // Out-of-range events still complete the handshake; they are just not stored.
    assign w_store       = w_push & w_in_range;
    assign bus.err_range = r_err_range;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_err_range <= 1'b0;
        else if (w_push && !w_in_range)
            r_err_range <= 1'b1;
    end
`else
    assign w_store       = w_push;
    assign bus.err_range = 1'b0;
`endif

    // Next state and next registered pixel outputs. IDLE and DRAIN behave alike
    // so a lone event plots on the edge right after it is queued.
    always_comb begin
        w_state_next  = r_state;
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_colour_next = r_colour;
        w_plot_next   = 1'b0;
        w_busy_next   = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                if (!w_sweep_last) begin
                    w_busy_next   = 1'b1;
                    w_plot_next   = 1'b1;
                    w_colour_next = DEAD_COLOUR;
                    if (r_x == C_X_LAST) begin
                        w_x_next = 8'd0;
                        w_y_next = r_y + 7'd1;
                    end else begin
                        w_x_next = r_x + 8'd1;
                    end
                end else if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_state_next  = ST_DRAIN;
                    w_plot_next   = 1'b1;
                    w_x_next      = w_head[15:8];
                    w_y_next      = w_head[7:1];
                    w_colour_next = w_head[0] ? ALIVE_COLOUR : DEAD_COLOUR;
                end else begin
                    w_state_next  = ST_IDLE;
                end
            end
            default: begin
                if (bus.clear_req) begin
                    w_state_next  = ST_CLEAR;
                    w_busy_next   = 1'b1;
                    w_plot_next   = 1'b1;
                    w_x_next      = 8'd0;
                    w_y_next      = 7'd0;
                    w_colour_next = DEAD_COLOUR;
                end else if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_state_next  = ST_DRAIN;
                    w_plot_next   = 1'b1;
                    w_x_next      = w_head[15:8];
                    w_y_next      = w_head[7:1];
                    w_colour_next = w_head[0] ? ALIVE_COLOUR : DEAD_COLOUR;
                end else begin
                    w_state_next  = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_colour <= DEAD_COLOUR;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_colour <= w_colour_next;
            r_plot   <= w_plot_next;
            r_busy   <= w_busy_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store)
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_count <= r_count + (ADDR_W+1)'(w_store) - (ADDR_W+1)'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_store)
            r_mem[r_wr_ptr] <= {bus.in_x, bus.in_y, bus.in_alive};
    end

    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.colour     = r_colour;
    assign bus.plot       = r_plot;
    assign bus.clear_busy = r_busy;
    assign bus.fifo_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_cell_plot_queue.sv
// ============================================================================
// tb_cell_plot_queue : self-checking bench for cell_plot_queue
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cell_plot_queue;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    cell_plot_queue_if #(.ADDR_W(4)) bus ();

    cell_plot_queue #(
        .DEPTH(16), .ADDR_W(4), .X_MAX(160), .Y_MAX(120),
        .ALIVE_COLOUR(3'b111), .DEAD_COLOUR(3'b000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] col_of(input logic alive);
        return alive ? 3'b111 : 3'b000;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_x = 8'd0; bus.in_y = 7'd0; bus.in_alive = 1'b0; bus.clear_req = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (bus.plot !== 1'b0) begin errors++; $display("FAIL reset_plot got=%b want=0", bus.plot); end
        checks++; if (bus.clear_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.clear_busy); end
        checks++; if (bus.fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", bus.fifo_count); end
        checks++; if ({bus.x, bus.y, bus.colour} !== 18'd0) begin errors++; $display("FAIL reset_pixel got=(%0d,%0d,%0d) want=(0,0,0)", bus.x, bus.y, bus.colour); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", bus.in_ready); end
        checks++; if (bus.err_range !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", bus.err_range); end
    endtask

    task automatic test_single();
        bus.in_valid = 1'b1; bus.in_x = 8'd5; bus.in_y = 7'd7; bus.in_alive = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        checks++; if (bus.plot !== 1'b0 || bus.fifo_count !== 5'd1) begin errors++; $display("FAIL single_queued plot=%b count=%0d want plot=0 count=1", bus.plot, bus.fifo_count); end
        @(negedge clock);
        checks++; if (bus.plot !== 1'b1 || bus.x !== 8'd5 || bus.y !== 7'd7 || bus.colour !== 3'b111) begin
            errors++; $display("FAIL single_plot got plot=%b (%0d,%0d,%0d) want plot=1 (5,7,7)", bus.plot, bus.x, bus.y, bus.colour); end
        @(negedge clock);
        checks++; if (bus.plot !== 1'b0 || bus.fifo_count !== 5'd0) begin errors++; $display("FAIL single_done plot=%b count=%0d want 0/0", bus.plot, bus.fifo_count); end
    endtask

    task automatic test_random_drain();
        pix_t q[$];
        pix_t e, pe;
        int   cnt = 0;
        logic acc;
        for (int c = 0; c < 300; c++) begin
            bus.in_valid = (c < 280) ? ($urandom_range(0, 99) < 60) : 1'b0;
            bus.in_x     = 8'($urandom_range(0, 159));
            bus.in_y     = 7'($urandom_range(0, 119));
            bus.in_alive = 1'($urandom_range(0, 1));
            checks++; if (bus.in_ready !== (cnt != 16)) begin errors++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, bus.in_ready, cnt != 16); end
            acc  = bus.in_valid && (cnt != 16);
            pe.x = bus.in_x; pe.y = bus.in_y; pe.c = col_of(bus.in_alive);
            @(negedge clock);
            if (cnt > 0) begin
                e = q.pop_front(); cnt--;
                checks++; if (bus.plot !== 1'b1 || bus.x !== e.x || bus.y !== e.y || bus.colour !== e.c) begin
                    errors++; $display("FAIL rnd_plot c=%0d got plot=%b (%0d,%0d,%0d) want plot=1 (%0d,%0d,%0d)", c, bus.plot, bus.x, bus.y, bus.colour, e.x, e.y, e.c); end
            end else begin
                checks++; if (bus.plot !== 1'b0) begin errors++; $display("FAIL rnd_idle c=%0d got plot=%b want=0", c, bus.plot); end
            end
            if (acc) begin q.push_back(pe); cnt++; end
            checks++; if (bus.fifo_count !== 5'(cnt)) begin errors++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, bus.fifo_count, cnt); end
        end
    endtask

    // Clear from IDLE while 17 events are offered: the sweep is checked pixel
    // by pixel, then the 16 accepted events must follow in order.
    task automatic test_clear_fill();
        pix_t q[$];
        pix_t e, pe;
        int   cnt = 0;
        int   k = 0;
        logic pv = 1'b0;
        bus.clear_req = 1'b1;
        @(negedge clock);
        bus.clear_req = 1'b0;
        for (int i = 0; i < 19200; i++) begin
            if (pv) begin q.push_back(pe); cnt++; k++; end
            checks++; if (bus.plot !== 1'b1 || bus.clear_busy !== 1'b1 || bus.x !== 8'(i % 160) || bus.y !== 7'(i / 160) || bus.colour !== 3'b000) begin
                errors++; if (errors < 20) $display("FAIL sweep_px i=%0d got plot=%b busy=%b (%0d,%0d,%0d) want (%0d,%0d,0)", i, bus.plot, bus.clear_busy, bus.x, bus.y, bus.colour, i % 160, i / 160); end
            checks++; if (bus.fifo_count !== 5'(cnt) || bus.in_ready !== (cnt != 16)) begin
                errors++; if (errors < 20) $display("FAIL fill_count i=%0d got count=%0d ready=%b want count=%0d ready=%b", i, bus.fifo_count, bus.in_ready, cnt, cnt != 16); end
            if (i < 100) begin
                bus.in_valid = 1'b1; bus.in_x = 8'(k * 7 + 1); bus.in_y = 7'(k + 3); bus.in_alive = 1'(k % 2);
            end else begin
                bus.in_valid = 1'b0;
            end
            pv   = bus.in_valid && (cnt != 16);
            pe.x = bus.in_x; pe.y = bus.in_y; pe.c = col_of(bus.in_alive);
            @(negedge clock);
        end
        checks++; if (k !== 16) begin errors++; $display("FAIL fill_accepted got=%0d want=16", k); end
        for (int j = 0; j < 16; j++) begin
            e = q.pop_front(); cnt--;
            checks++; if (bus.plot !== 1'b1 || bus.clear_busy !== 1'b0 || bus.x !== e.x || bus.y !== e.y || bus.colour !== e.c || bus.fifo_count !== 5'(cnt)) begin
                errors++; $display("FAIL fill_drain j=%0d got plot=%b busy=%b (%0d,%0d,%0d) count=%0d want (%0d,%0d,%0d) count=%0d", j, bus.plot, bus.clear_busy, bus.x, bus.y, bus.colour, bus.fifo_count, e.x, e.y, e.c, cnt); end
            @(negedge clock);
        end
        checks++; if (bus.plot !== 1'b0 || bus.fifo_count !== 5'd0) begin errors++; $display("FAIL fill_end plot=%b count=%0d want 0/0", bus.plot, bus.fifo_count); end
    endtask

    task automatic test_clear_mid_drain();
        pix_t ev[4];
        int   busy_cycles = 1;
        for (int j = 0; j < 4; j++) begin
            ev[j].x = 8'(20 + j * 11); ev[j].y = 7'(100 - j * 9); ev[j].c = col_of(1'(j % 2));
        end
        for (int j = 0; j < 4; j++) begin
            bus.in_valid = 1'b1; bus.in_x = ev[j].x; bus.in_y = ev[j].y; bus.in_alive = 1'(j % 2);
            bus.clear_req = (j == 3);
            @(negedge clock);
            if (j >= 1 && j <= 2) begin
                checks++; if (bus.plot !== 1'b1 || bus.x !== ev[j-1].x || bus.y !== ev[j-1].y || bus.colour !== ev[j-1].c) begin
                    errors++; $display("FAIL mid_pre j=%0d got plot=%b (%0d,%0d,%0d) want (%0d,%0d,%0d)", j - 1, bus.plot, bus.x, bus.y, bus.colour, ev[j-1].x, ev[j-1].y, ev[j-1].c); end
            end
        end
        bus.in_valid = 1'b0; bus.clear_req = 1'b0;
        checks++; if (bus.clear_busy !== 1'b1 || bus.x !== 8'd0 || bus.y !== 7'd0 || bus.fifo_count !== 5'd2) begin
            errors++; $display("FAIL mid_start got busy=%b (%0d,%0d) count=%0d want busy=1 (0,0) count=2", bus.clear_busy, bus.x, bus.y, bus.fifo_count); end
        for (int i = 1; i < 19200; i++) begin
            bus.clear_req = (i == 5000);
            @(negedge clock);
            if (bus.clear_busy === 1'b1) busy_cycles++;
        end
        bus.clear_req = 1'b0;
        checks++; if (busy_cycles !== 19200) begin errors++; $display("FAIL mid_busy_len got=%0d want=19200", busy_cycles); end
        for (int j = 2; j < 4; j++) begin
            @(negedge clock);
            checks++; if (bus.plot !== 1'b1 || bus.clear_busy !== 1'b0 || bus.x !== ev[j].x || bus.y !== ev[j].y || bus.colour !== ev[j].c) begin
                errors++; $display("FAIL mid_post j=%0d got plot=%b busy=%b (%0d,%0d,%0d) want (%0d,%0d,%0d)", j, bus.plot, bus.clear_busy, bus.x, bus.y, bus.colour, ev[j].x, ev[j].y, ev[j].c); end
        end
        repeat (3) @(negedge clock);
        checks++; if (bus.plot !== 1'b0 || bus.clear_busy !== 1'b0 || bus.fifo_count !== 5'd0) begin
            errors++; $display("FAIL mid_end plot=%b busy=%b count=%0d want 0/0/0", bus.plot, bus.clear_busy, bus.fifo_count); end
    endtask

    task automatic test_range();
        pix_t got[$];
        pix_t exp_q[$];
        pix_t p;
        logic exp_err;
`ifdef CELL_PLOT_RANGE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
        p.x = 8'd160; p.y = 7'd0; p.c = 3'b111; exp_q.push_back(p);
`endif
        p.x = 8'd3; p.y = 7'd119; p.c = 3'b000; exp_q.push_back(p);
        bus.in_valid = 1'b1; bus.in_x = 8'd160; bus.in_y = 7'd0; bus.in_alive = 1'b1;
        @(negedge clock);
        bus.in_x = 8'd3; bus.in_y = 7'd119; bus.in_alive = 1'b0;
        @(negedge clock);
        bus.in_valid = 1'b0;
        if (bus.plot === 1'b1) begin p.x = bus.x; p.y = bus.y; p.c = bus.colour; got.push_back(p); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (bus.plot === 1'b1) begin p.x = bus.x; p.y = bus.y; p.c = bus.colour; got.push_back(p); end
        end
        checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL range_plots got=%0d want=%0d", got.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size() && j < got.size(); j++) begin
            checks++; if (got[j].x !== exp_q[j].x || got[j].y !== exp_q[j].y || got[j].c !== exp_q[j].c) begin
                errors++; $display("FAIL range_pixel j=%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", j, got[j].x, got[j].y, got[j].c, exp_q[j].x, exp_q[j].y, exp_q[j].c); end
        end
        checks++; if (bus.err_range !== exp_err) begin errors++; $display("FAIL range_err got=%b want=%b", bus.err_range, exp_err); end
    endtask

    task automatic test_reset_mid_sweep();
        bus.clear_req = 1'b1;
        @(negedge clock);
        bus.clear_req = 1'b0;
        for (int i = 0; i < 1640; i++) begin
            bus.in_valid = (i >= 1 && i <= 3); bus.in_x = 8'(i); bus.in_y = 7'(i); bus.in_alive = 1'b1;
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.x !== 8'd40 || bus.y !== 7'd10 || bus.clear_busy !== 1'b1 || bus.fifo_count !== 5'd3) begin
            errors++; $display("FAIL rst_pre got (%0d,%0d) busy=%b count=%0d want (40,10) busy=1 count=3", bus.x, bus.y, bus.clear_busy, bus.fifo_count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.plot !== 1'b0 || bus.clear_busy !== 1'b0 || bus.fifo_count !== 5'd0) begin
            errors++; $display("FAIL rst_async got plot=%b busy=%b count=%0d want 0/0/0", bus.plot, bus.clear_busy, bus.fifo_count); end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (bus.plot !== 1'b0 || bus.clear_busy !== 1'b0 || bus.fifo_count !== 5'd0 || bus.err_range !== 1'b0) begin
            errors++; $display("FAIL rst_after got plot=%b busy=%b count=%0d err=%b want 0/0/0/0", bus.plot, bus.clear_busy, bus.fifo_count, bus.err_range); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_random_drain();
        test_clear_fill();
        test_clear_mid_drain();
        test_range();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
